alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
Registered, parameterised integer ALU with a 4-bit opcode.
- Each cycle with enable high, computes one arithmetic, logic, compare or shift operation on unsigned operands A and B.
- Captures the result into a double-width output register and pulses a valid flag.
- Execution unit of the register-file/command datapath; one operation per clock, no back-pressure.

Parameters:
- DATA_WIDTH, 8, width of operands A and B; result width is 2*DATA_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- A  input  DATA_WIDTH  operand A, unsigned.
- B  input  DATA_WIDTH  operand B, unsigned.
- ALU_function  input  4  opcode.
- enable  input  1  operation request, sampled each rising edge.
- ALU_result  output  2*DATA_WIDTH  registered result.
- ALU_result_valid  output  1  high for the cycle after an enabled edge.
- ALU_flags  output  2  {carry, zero}; present only with ALU_FLAGS_EN.

Behaviour:
- Reset: reset low immediately clears ALU_result to 0 and ALU_result_valid to 0 (and ALU_flags to 0), regardless of clk. This also applies mid-operation.
- Latency: 1 cycle. At a rising edge with enable=1, ALU_result <= f(A,B,ALU_function) and ALU_result_valid <= 1.
- At a rising edge with enable=0: ALU_result holds its previous value and ALU_result_valid <= 0.
- Back-to-back enabled cycles are allowed; valid stays high, and the result updates every cycle.
- Width rule: operands are zero-extended to 2*DATA_WIDTH before the operation, and the result is truncated to 2*DATA_WIDTH.
- Opcodes:
  - 0000 ADD: A+B; the carry appears in bit DATA_WIDTH.
  - 0001 SUB: A-B, modulo 2^(2*DATA_WIDTH). Example: A<B gives upper bits all ones (0x2A-0x54 = 0xFFD6).
  - 0010 MUL: full unsigned product A*B.
  - 0011 DIV: unsigned quotient floor(A/B). B=0 gives result 0; valid still asserts.
  - 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR: bitwise over DATA_WIDTH bits, with the upper DATA_WIDTH bits = 0.
  - 1010 EQ: 1 if A==B, else 0.
  - 1011 GT: 2 if A>B, else 0.
  - 1100 LT: 3 if A<B, else 0.
  - 1101 SHR: A>>1 (logical).
  - 1110 SHL: A<<1, keeping the shifted-out bit in bit DATA_WIDTH.
  - 1111: result 0; valid still asserts.
- The operation logic is purely combinational from the A, B and ALU_function values present at the sampling edge; there is no internal state other than the output registers.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: adds output ALU_flags[1:0], registered alongside ALU_result on enabled edges.
  - zero = (next ALU_result == 0).
  - carry = bit DATA_WIDTH of the ADD/SHL result, or the borrow (A<B) for SUB; 0 for all other opcodes.
  - Flags hold when enable=0 and clear on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode constants (ALU_ADD=4'h0 … ALU_SHL=4'hE);
  - the compare result codes (CMP_EQ=1, CMP_GT=2, CMP_LT=3).
- A combinational sub-module alu_comb (opcode, A, B -> result, carry) is natural.
- alu_core itself keeps only the enable gating and the async-reset output registers.

Test Plan:
- DATA_WIDTH=8. Hold reset low for 1 cycle, then release.
  - ALU_result=0x0000 and ALU_result_valid=0 while reset is low.
- enable=1, A=0x54, B=0x2A, opcode 0000/0001/0010/0011 on successive cycles.
  - One cycle later: 0x007E, 0x002A, 0x0DC8, 0x0002; valid=1 each cycle.
- Logic: A=0x54,B=0x2F AND gives 0x0004; A=0xF4,B=0x2C OR gives 0x00FC.
  - A=0xF4,B=0x2C XOR gives 0x00D8; NOR gives 0x0003.
- Compare/shift with A=0x80, B=0x10:
  - EQ gives 0, GT gives 0x0002, LT gives 0.
  - SHL gives 0x0100, SHR gives 0x0040.
- Edge cases:
  - SUB with A=0x2A, B=0x54 gives 0xFFD6.
  - DIV with B=0 gives 0x0000 and valid=1.
  - ADD 0xFF+0xFF gives 0x01FE.
- Control:
  - Drop enable: result holds its last value and valid goes to 0 the next cycle.
  - Assert reset mid-stream, between clock edges: outputs clear immediately, without waiting for a clock edge.
- Only when compiled with ALU_FLAGS_EN:
  - ADD 0xFF+0x01 gives flags {carry=1, zero=0}.
  - SUB 0x10-0x10 gives {carry=0, zero=1}.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and compare-code constants shared by the ALU files
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_MUL  = 4'h2;
  localparam logic [3:0] ALU_DIV  = 4'h3;
  localparam logic [3:0] ALU_AND  = 4'h4;
  localparam logic [3:0] ALU_OR   = 4'h5;
  localparam logic [3:0] ALU_NAND = 4'h6;
  localparam logic [3:0] ALU_NOR  = 4'h7;
  localparam logic [3:0] ALU_XOR  = 4'h8;
  localparam logic [3:0] ALU_XNOR = 4'h9;
  localparam logic [3:0] ALU_EQ   = 4'hA;
  localparam logic [3:0] ALU_GT   = 4'hB;
  localparam logic [3:0] ALU_LT   = 4'hC;
  localparam logic [3:0] ALU_SHR  = 4'hD;
  localparam logic [3:0] ALU_SHL  = 4'hE;
  localparam logic [1:0] CMP_EQ = 2'd1;
  localparam logic [1:0] CMP_GT = 2'd2;
  localparam logic [1:0] CMP_LT = 2'd3;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational ALU datapath
// Ports: op (opcode), a/b (unsigned operands), result (2*DATA_WIDTH), carry (ADD/SHL carry-out, SUB borrow)
module alu_comb import alu_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [3:0]              op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic                    carry
);
  localparam int RW = 2*DATA_WIDTH;
  logic [RW-1:0] ax, bx, sum, quot;
  logic [DATA_WIDTH-1:0] lo;
  assign ax = RW'(a);
  assign bx = RW'(b);
  assign sum = ax + bx;
  // A zero divisor yields 0 rather than an undefined quotient
  assign quot = (b == '0) ? '0 : ax / bx;
  always_comb begin
    lo = '0;
    case (op)
      ALU_AND:  lo = a & b;
      ALU_OR:   lo = a | b;
      ALU_NAND: lo = ~(a & b);
      ALU_NOR:  lo = ~(a | b);
      ALU_XOR:  lo = a ^ b;
      ALU_XNOR: lo = ~(a ^ b);
      default:  lo = '0;
    endcase
    result = RW'(lo);
    case (op)
      ALU_ADD: result = sum;
      ALU_SUB: result = ax - bx;
      ALU_MUL: result = ax * bx;
      ALU_DIV: result = quot;
      ALU_EQ:  result = (a == b) ? RW'(CMP_EQ) : '0;
      ALU_GT:  result = (a > b) ? RW'(CMP_GT) : '0;
      ALU_LT:  result = (a < b) ? RW'(CMP_LT) : '0;
      ALU_SHR: result = ax >> 1;
      ALU_SHL: result = ax << 1;
      default: ;
    endcase
    carry = (op == ALU_ADD) ? sum[DATA_WIDTH] :
            (op == ALU_SUB) ? (a < b) :
            (op == ALU_SHL) ? a[DATA_WIDTH-1] : 1'b0;
  end
endmodule

// File: rtl/alu_core.sv
// alu_core: registered ALU, one enabled operation per clock, async active-low reset
// Ports: clk, reset (async, active low), A/B operands, ALU_function opcode, enable,
//        ALU_result (2*DATA_WIDTH), ALU_result_valid, ALU_flags {carry, zero} when ALU_FLAGS_EN is defined
module alu_core import alu_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  input  logic [3:0]              ALU_function,
  input  logic                    enable,
  output logic [2*DATA_WIDTH-1:0] ALU_result,
  output logic                    ALU_result_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic [1:0]              ALU_flags
`endif
);
  logic [2*DATA_WIDTH-1:0] res;
  logic carry;
  alu_comb #(.DATA_WIDTH(DATA_WIDTH)) u_comb (
    .op(ALU_function),
    .a(A),
    .b(B),
    .result(res),
    .carry(carry)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ALU_result <= '0;
      ALU_result_valid <= 1'b0;
    end else begin
      ALU_result_valid <= enable;
      if (enable) ALU_result <= res;
    end
`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) ALU_flags <= '0;
    else if (enable) ALU_flags <= {carry, res == '0};
`else
  logic unused_carry;
  assign unused_carry = carry;
`endif
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core
module tb_alu_core;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] A, B;
  logic [3:0] ALU_function;
  logic enable;
  logic [15:0] ALU_result;
  logic ALU_result_valid;
`ifdef ALU_FLAGS_EN
  logic [1:0] ALU_flags;
`endif
  typedef struct {
    logic [15:0] res;
    logic [1:0]  flg;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  alu_core #(.DATA_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .A(A),
    .B(B),
    .ALU_function(ALU_function),
    .enable(enable),
    .ALU_result(ALU_result),
    .ALU_result_valid(ALU_result_valid)
`ifdef ALU_FLAGS_EN
    ,
    .ALU_flags(ALU_flags)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      4'd0:  r = ia + ib;
      4'd1:  r = ia - ib;
      4'd2:  r = ia * ib;
      4'd3:  r = (ib == 0) ? 0 : ia / ib;
      4'd4:  r = ia & ib;
      4'd5:  r = ia | ib;
      4'd6:  r = 255 - (ia & ib);
      4'd7:  r = 255 - (ia | ib);
      4'd8:  r = ia ^ ib;
      4'd9:  r = 255 - (ia ^ ib);
      4'd10: r = (ia == ib) ? 1 : 0;
      4'd11: r = (ia > ib) ? 2 : 0;
      4'd12: r = (ia < ib) ? 3 : 0;
      4'd13: r = ia / 2;
      4'd14: r = ia * 2;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction
  function automatic logic [1:0] flag_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic c;
    c = (op == 4'd0) ? (int'(a) + int'(b) > 255) :
        (op == 4'd1) ? (a < b) :
        (op == 4'd14) ? (a >= 8'h80) : 1'b0;
    return {c, model(op, a, b) == 16'h0};
  endfunction
  task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    ALU_function = op;
    enable = 1'b1;
    e.res = exp;
    e.flg = flag_model(op, a, b);
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (reset === 1'b1 && ALU_result_valid === 1'b1) begin
      if (q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("result", 32'(ALU_result), 32'(e.res));
`ifdef ALU_FLAGS_EN
        check("flags", 32'(ALU_flags), 32'(e.flg));
`endif
      end
    end
  end
  initial begin
    logic [3:0] op;
    logic [7:0] a, b;
    reset = 1'b0;
    enable = 1'b0;
    A = '0;
    B = '0;
    ALU_function = '0;
    #1;
    check("reset_result", 32'(ALU_result), 32'h0);
    check("reset_valid", 32'(ALU_result_valid), 32'h0);
`ifdef ALU_FLAGS_EN
    check("reset_flags", 32'(ALU_flags), 32'h0);
`endif
    @(negedge clk);
    check("reset_hold_result", 32'(ALU_result), 32'h0);
    check("reset_hold_valid", 32'(ALU_result_valid), 32'h0);
    reset = 1'b1;
    apply(4'h0, 8'h54, 8'h2A, 16'h007E);
    apply(4'h1, 8'h54, 8'h2A, 16'h002A);
    apply(4'h2, 8'h54, 8'h2A, 16'h0DC8);
    apply(4'h3, 8'h54, 8'h2A, 16'h0002);
    apply(4'h4, 8'h54, 8'h2F, 16'h0004);
    apply(4'h5, 8'hF4, 8'h2C, 16'h00FC);
    apply(4'h8, 8'hF4, 8'h2C, 16'h00D8);
    apply(4'h7, 8'hF4, 8'h2C, 16'h0003);
    apply(4'hA, 8'h80, 8'h10, 16'h0000);
    apply(4'hB, 8'h80, 8'h10, 16'h0002);
    apply(4'hC, 8'h80, 8'h10, 16'h0000);
    apply(4'hE, 8'h80, 8'h10, 16'h0100);
    apply(4'hD, 8'h80, 8'h10, 16'h0040);
    apply(4'h1, 8'h2A, 8'h54, 16'hFFD6);
    apply(4'h3, 8'h2A, 8'h00, 16'h0000);
    apply(4'h0, 8'hFF, 8'h01, 16'h0100);
    apply(4'h1, 8'h10, 8'h10, 16'h0000);
    apply(4'hF, 8'h12, 8'h34, 16'h0000);
    apply(4'h0, 8'hFF, 8'hFF, 16'h01FE);
    @(negedge clk);
    enable = 1'b0;
    A = 8'h11;
    B = 8'h22;
    @(negedge clk);
    #1;
    check("hold_valid", 32'(ALU_result_valid), 32'h0);
    check("hold_result", 32'(ALU_result), 32'h01FE);
    @(negedge clk);
    #1;
    check("hold_result2", 32'(ALU_result), 32'h01FE);
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom_range(0, 255));
      b = (i % 8 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      apply(op, a, b, model(op, a, b));
    end
    apply(4'h2, 8'hFF, 8'hFF, 16'hFE01);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_result", 32'(ALU_result), 32'h0);
    check("midreset_valid", 32'(ALU_result_valid), 32'h0);
`ifdef ALU_FLAGS_EN
    check("midreset_flags", 32'(ALU_flags), 32'h0);
`endif
    q.delete();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("reset_after_edge", 32'(ALU_result), 32'h0);
    reset = 1'b1;
    apply(4'h9, 8'hF0, 8'h0F, 16'h0000);
    apply(4'h6, 8'hF0, 8'hFF, 16'h000F);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
